// File: rtl/put_get_arb_pkg.sv
// Shared constants and helpers for the put/get arbiter slice.
package put_get_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_TAG_DEPTH = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Up to 8 requesters; callers zero-pad narrower vectors.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding requester tags for puts still awaiting their get.
module tag_fifo import put_get_arb_pkg::*; #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign front   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/put_get_arbiter.sv
// Round-robin sharing of one mkHardware put/get pair with in-order result routing.
// Optional per-requester put counters when ARB_PERF_CNT_EN is defined.
module put_get_arbiter import put_get_arb_pkg::*; #(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         put_datas,
  output logic                      EN_put,
  input  logic                      RDY_put,
  input  logic [DATA_W-1:0]         get,
  output logic                      EN_get,
  input  logic                      RDY_get
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_cnt
`endif
);

  localparam int unsigned TAG_W = clog2(NUM_REQ);

  logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d, winner, head;
  logic [NUM_REQ-1:0]   rotated, grant_rot, grant_oh, head_oh;
  logic [2*NUM_REQ-1:0] dbl_req, dbl_grant;
  logic [7:0]           grant_pad;
  logic                 found, tag_full, tag_empty, put_fire, get_fire;

  // Rotate requests so bit 0 is rr_ptr, pick the lowest, rotate the grant back.
  always_comb begin
    dbl_req   = {req_valid, req_valid} >> rr_ptr_q;
    rotated   = dbl_req[NUM_REQ-1:0];
    grant_rot = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rotated[i] && !found) begin
        grant_rot[i] = 1'b1;
        found        = 1'b1;
      end
    end
    dbl_grant = {grant_rot, grant_rot} << rr_ptr_q;
    grant_oh  = dbl_grant[2*NUM_REQ-1:NUM_REQ];
    grant_pad = '0;
    grant_pad[NUM_REQ-1:0] = grant_oh;
    winner    = TAG_W'(onehot_to_idx(grant_pad));
    rr_ptr_d  = (winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    put_datas = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) put_datas = put_datas | req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) head_oh[i] = (head == TAG_W'(i));
  end

  // Full blocks the put even when a pop frees a slot in the same cycle.
  assign put_fire  = (|req_valid) & RDY_put & ~tag_full;
  assign get_fire  = RDY_get & ~tag_empty & (|(head_oh & rsp_ready));
  assign EN_put    = put_fire & RST_N;
  assign EN_get    = get_fire & RST_N;
  assign req_ready = EN_put ? grant_oh : '0;
  assign rsp_valid = (RST_N && RDY_get && !tag_empty) ? head_oh : '0;
  assign rsp_data  = get;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rr_ptr_q <= '0;
    else if (put_fire) rr_ptr_q <= rr_ptr_d;
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push    (put_fire),
    .pop     (get_fire),
    .data_in (winner),
    .front   (head),
    .full    (tag_full),
    .empty   (tag_empty)
  );

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_q [NUM_REQ];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REQ; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (put_fire && grant_oh[i] && perf_q[i] != 16'hFFFF) perf_q[i] <= perf_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) perf_cnt[i*16 +: 16] = perf_q[i];
  end
`endif

endmodule

// File: tb/tb_put_get_arbiter.sv
// Directed bench for put_get_arbiter with a tag scoreboard and round-robin reference.
module tb_put_get_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TD = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    rsp_data, put_datas, get;
  logic             EN_put, RDY_put, EN_get, RDY_get;
`ifdef ARB_PERF_CNT_EN
  logic [NR*16-1:0] perf_cnt;
`endif

  always #5 CLK = ~CLK;

  put_get_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .put_datas (put_datas),
    .EN_put    (EN_put),
    .RDY_put   (RDY_put),
    .get       (get),
    .EN_get    (EN_get),
    .RDY_get   (RDY_get)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [DW-1:0] reqd [NR];
  int unsigned exp_rr;
  int unsigned sb [$];

  function automatic int unsigned model_winner(input int unsigned rr, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      int unsigned i;
      i = (rr + k) % NR;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare against the reference, update scoreboard, advance.
  task automatic step(input logic [NR-1:0] valid, input logic rdy_get,
                      input logic [NR-1:0] rready, input logic [DW-1:0] getv);
    logic          exp_put, exp_get;
    logic [NR-1:0] exp_rv;
    int unsigned   w;
    req_valid = valid;
    RDY_get   = rdy_get;
    rsp_ready = rready;
    get       = getv;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = reqd[i];
    #1;
    exp_put = (|valid) && RDY_put && (sb.size() < TD);
    w       = model_winner(exp_rr, valid);
    exp_rv  = (rdy_get && sb.size() > 0) ? NR'(1) << sb[0] : '0;
    exp_get = |(exp_rv & rready);
    chk("en_put", 64'(EN_put), 64'(exp_put));
    chk("req_ready", 64'(req_ready), exp_put ? 64'(1) << w : 64'(0));
    if (exp_put) chk("put_datas", 64'(put_datas), 64'(reqd[w]));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("en_get", 64'(EN_get), 64'(exp_get));
    chk("rsp_data", 64'(rsp_data), 64'(getv));
    if (exp_get) void'(sb.pop_front());
    if (exp_put) begin
      sb.push_back(w);
      exp_rr = (w + 1) % NR;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N     = 1'b0;
    req_valid = '1;
    RDY_put   = 1'b1;
    RDY_get   = 1'b1;
    rsp_ready = '1;
    #1;
    chk("rst_en_put", 64'(EN_put), 64'(0));
    chk("rst_en_get", 64'(EN_get), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    sb.delete();
    exp_rr = 0;
    @(posedge CLK);
    #1;
    RST_N     = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    get      = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) reqd[i] = 32'h100 + 32'(i);
    do_reset();

    // Round-robin fill: grants 0,1,2,3,0,1,2,3 then full on the ninth cycle.
    for (int c = 0; c < 9; c++) step('1, 1'b0, '1, '0);

    // Full plus pop: pop only, then put resumes next cycle.
    step('1, 1'b1, '1, 32'hA0);
    step('1, 1'b1, '1, 32'hA1);
    for (int n = 0; n < TD && sb.size() > 0; n++) step('0, 1'b1, '1, 32'hB0 + 32'(n));

    // Orphan get on an empty FIFO, then put blocked by RDY_put.
    step('0, 1'b1, '1, 32'hDEAD);
    step('0, 1'b1, '1, 32'hBEEF);
    RDY_put = 1'b0;
    step('1, 1'b0, '1, '0);
    RDY_put = 1'b1;

    // Routing: req1 then req3, results return in order.
    reqd[1] = 32'h4;
    reqd[3] = 32'h8;
    step(4'b1010, 1'b0, '1, '0);
    step(4'b1000, 1'b0, '1, '0);
    step('0, 1'b1, '1, 32'h14);
    step('0, 1'b1, '1, 32'h18);

    // Back-pressure: head is req2, its rsp_ready low for 5 cycles.
    step(4'b0100, 1'b0, '1, '0);
    step(4'b0001, 1'b0, '1, '0);
    for (int c = 0; c < 5; c++) step('0, 1'b1, 4'b1011, 32'h22);
    step('0, 1'b1, '1, 32'h22);
    step('0, 1'b1, '1, 32'h33);
    step('0, 1'b1, '1, 32'h44);

    // Reset mid-operation drops outstanding tags.
    step('1, 1'b0, '1, '0);
    step('1, 1'b0, '1, '0);
    do_reset();
    step('0, 1'b1, '1, 32'h55);

`ifdef ARB_PERF_CNT_EN
    for (int c = 0; c < 6; c++) step(4'b0001, 1'b0, '1, '0);
    chk("perf_cnt0", 64'(perf_cnt[15:0]), 64'(6));
    chk("perf_cnt1", 64'(perf_cnt[31:16]), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
